// File: rtl/bias_add_stream_if.sv
// Handshake bundle for bias_add_stream: joined matmul/bias input streams and the
// biased output stream with row/tensor boundary flags.
interface bias_add_stream_if #(
  parameter int DATA_IN_WIDTH  = 16,
  parameter int BIAS_WIDTH     = 16,
  parameter int DATA_OUT_WIDTH = 16,
  parameter int PARALLELISM    = 1
);
  logic [PARALLELISM-1:0][DATA_IN_WIDTH-1:0]  data_in;
  logic                                       data_in_valid;
  logic                                       data_in_ready;
  logic [PARALLELISM-1:0][BIAS_WIDTH-1:0]     bias;
  logic                                       bias_valid;
  logic                                       bias_ready;
  logic [PARALLELISM-1:0][DATA_OUT_WIDTH-1:0] data_out;
  logic                                       data_out_valid;
  logic                                       data_out_ready;
  logic                                       data_out_row_last;
  logic                                       data_out_tensor_last;

  // Upstream sources and downstream sink view.
  modport master (
    output data_in, data_in_valid, bias, bias_valid, data_out_ready,
    input  data_in_ready, bias_ready, data_out, data_out_valid,
           data_out_row_last, data_out_tensor_last
  );

  // The bias adder itself.
  modport slave (
    input  data_in, data_in_valid, bias, bias_valid, data_out_ready,
    output data_in_ready, bias_ready, data_out, data_out_valid,
           data_out_row_last, data_out_tensor_last
  );
endinterface

// File: rtl/bias_add_stream.sv
// Joins matmul output with the bias stream, adds with fixed-point alignment and saturation.
// Latency 1 cycle into a 2-entry skid buffer; input readies depend only on registered occupancy.
module bias_add_stream #(
  parameter int DATA_IN_WIDTH     = 16,
  parameter int DATA_IN_FRAC      = 6,
  parameter int BIAS_WIDTH        = 16,
  parameter int BIAS_FRAC         = 3,
  parameter int DATA_OUT_WIDTH    = 16,
  parameter int TENSOR_SIZE_DIM_0 = 32,
  parameter int TENSOR_SIZE_DIM_1 = 4,
  parameter int PARALLELISM       = 1,
  parameter int DEPTH_DIM_0       = TENSOR_SIZE_DIM_0 / PARALLELISM
) (
  input  logic              clk,
  input  logic              rst,
  bias_add_stream_if.slave  bus
);

  localparam int SHIFT  = DATA_IN_FRAC - BIAS_FRAC;
  localparam int SUM_W  = DATA_IN_WIDTH + 2;
  localparam int SAT_W  = (SUM_W > DATA_OUT_WIDTH) ? SUM_W : DATA_OUT_WIDTH + 1;
  localparam int BEAT_W = (DEPTH_DIM_0 > 1) ? $clog2(DEPTH_DIM_0) : 1;
  localparam int ROW_W  = (TENSOR_SIZE_DIM_1 > 1) ? $clog2(TENSOR_SIZE_DIM_1) : 1;

  localparam logic signed [SAT_W-1:0] OUT_MAX =
    SAT_W'($signed({1'b0, {(DATA_OUT_WIDTH-1){1'b1}}}));
  localparam logic signed [SAT_W-1:0] OUT_MIN =
    SAT_W'($signed({1'b1, {(DATA_OUT_WIDTH-1){1'b0}}}));

  if (BIAS_FRAC > DATA_IN_FRAC) begin : g_frac_check
    $error("bias_add_stream: BIAS_FRAC must not exceed DATA_IN_FRAC");
  end
  if ((TENSOR_SIZE_DIM_0 % PARALLELISM) != 0) begin : g_par_check
    $error("bias_add_stream: PARALLELISM must divide TENSOR_SIZE_DIM_0");
  end

  typedef struct packed {
    logic [PARALLELISM-1:0][DATA_OUT_WIDTH-1:0] dat;
    logic                                       row_last;
    logic                                       tensor_last;
  } entry_t;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } occ_e;

  occ_e                                       r_occ;
  occ_e                                       w_occ_nxt;
  entry_t                                     r_head;
  entry_t                                     r_tail;
  entry_t                                     w_entry;
  logic [BEAT_W-1:0]                          r_beat;
  logic [ROW_W-1:0]                           r_row;
  logic [PARALLELISM-1:0][DATA_OUT_WIDTH-1:0] w_sat;
  logic                                       w_can_accept;
  logic                                       w_xfer;
  logic                                       w_pop;
  logic                                       w_row_last;
  logic                                       w_tensor_last;
  logic                                       w_head_ld_new;
  logic                                       w_head_ld_tail;
  logic                                       w_tail_ld;

  // Readies look only at registered occupancy, so data_out_ready never reaches them.
  assign w_can_accept       = (r_occ != S_FULL) && !rst;
  assign bus.data_in_ready  = bus.bias_valid & w_can_accept;
  assign bus.bias_ready     = bus.data_in_valid & w_can_accept;
  assign w_xfer             = bus.data_in_valid & bus.bias_valid & w_can_accept;
  assign w_pop              = (r_occ != S_EMPTY) & bus.data_out_ready;

  for (genvar i = 0; i < PARALLELISM; i++) begin : g_lane
    logic signed [DATA_IN_WIDTH:0] w_bias_al;
    logic signed [SUM_W-1:0]       w_sum;
    logic signed [SAT_W-1:0]       w_sum_x;

    assign w_bias_al = (DATA_IN_WIDTH+1)'($signed(bus.bias[i])) <<< SHIFT;
    assign w_sum     = SUM_W'($signed(bus.data_in[i])) + SUM_W'(w_bias_al);
    assign w_sum_x   = SAT_W'(w_sum);
    assign w_sat[i]  = (w_sum_x > OUT_MAX) ? DATA_OUT_WIDTH'(OUT_MAX) :
                       (w_sum_x < OUT_MIN) ? DATA_OUT_WIDTH'(OUT_MIN) :
                                             DATA_OUT_WIDTH'(w_sum_x);
  end

  assign w_row_last    = (r_beat == BEAT_W'(DEPTH_DIM_0 - 1));
  assign w_tensor_last = w_row_last && (r_row == ROW_W'(TENSOR_SIZE_DIM_1 - 1));

  always_comb begin
    w_entry             = '0;
    w_entry.dat         = w_sat;
    w_entry.row_last    = w_row_last;
    w_entry.tensor_last = w_tensor_last;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_beat <= '0;
      r_row  <= '0;
    end else if (w_xfer) begin
      if (w_row_last) begin
        r_beat <= '0;
        r_row  <= w_tensor_last ? '0 : r_row + 1'b1;
      end else begin
        r_beat <= r_beat + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_occ <= S_EMPTY;
    end else begin
      r_occ <= w_occ_nxt;
    end
  end

  // Push into FULL cannot happen because the readies are already low there.
  always_comb begin
    w_occ_nxt      = r_occ;
    w_head_ld_new  = 1'b0;
    w_head_ld_tail = 1'b0;
    w_tail_ld      = 1'b0;
    case (r_occ)
      S_EMPTY: begin
        if (w_xfer) begin
          w_occ_nxt     = S_ONE;
          w_head_ld_new = 1'b1;
        end
      end
      S_ONE: begin
        if (w_xfer && w_pop) begin
          w_head_ld_new = 1'b1;
        end else if (w_xfer) begin
          w_tail_ld = 1'b1;
          w_occ_nxt = S_FULL;
        end else if (w_pop) begin
          w_occ_nxt = S_EMPTY;
        end
      end
      S_FULL: begin
        if (w_pop) begin
          w_head_ld_tail = 1'b1;
          w_occ_nxt      = S_ONE;
        end
      end
      default: begin
        w_occ_nxt = S_EMPTY;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_head <= '0;
      r_tail <= '0;
    end else begin
      if (w_head_ld_new) begin
        r_head <= w_entry;
      end else if (w_head_ld_tail) begin
        r_head <= r_tail;
      end
      if (w_tail_ld) begin
        r_tail <= w_entry;
      end
    end
  end

  assign bus.data_out             = r_head.dat;
  assign bus.data_out_valid       = (r_occ != S_EMPTY);
  assign bus.data_out_row_last    = r_head.row_last;
  assign bus.data_out_tensor_last = r_head.tensor_last;

endmodule

// File: tb/tb_bias_add_stream.sv
// Directed bench for bias_add_stream with an expected-result queue fed at input transfer
// and drained at output transfer.
module tb_bias_add_stream;
  localparam int DIW = 16;
  localparam int DIF = 6;
  localparam int BW  = 16;
  localparam int BF  = 3;
  localparam int DOW = 16;
  localparam int D0  = 32;
  localparam int D1  = 4;
  localparam int P   = 1;

  typedef struct {
    logic [15:0] dat;
    logic        rl;
    logic        tl;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bias_add_stream_if #(.DATA_IN_WIDTH(DIW), .BIAS_WIDTH(BW), .DATA_OUT_WIDTH(DOW),
                       .PARALLELISM(P)) bus ();

  bias_add_stream #(
    .DATA_IN_WIDTH(DIW), .DATA_IN_FRAC(DIF), .BIAS_WIDTH(BW), .BIAS_FRAC(BF),
    .DATA_OUT_WIDTH(DOW), .TENSOR_SIZE_DIM_0(D0), .TENSOR_SIZE_DIM_1(D1),
    .PARALLELISM(P)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  exp_t q[$];
  int   vectors = 0;
  int   errors  = 0;
  int   m_beat  = 0;
  int   m_row   = 0;
  int   n_in    = 0;
  int   n_out   = 0;
  int   n_rl    = 0;
  int   n_tl    = 0;
  logic        prev_stall = 1'b0;
  logic [18:0] prev_out   = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Q9.6 + (Q12.3 aligned by 3 bits), clamped to 16-bit signed.
  function automatic logic [15:0] model_add(input logic [15:0] d, input logic [15:0] b);
    int s;
    s = int'($signed(d)) + int'($signed(b)) * 8;
    if (s > 32767) s = 32767;
    else if (s < -32768) s = -32768;
    return s[15:0];
  endfunction

  always @(negedge clk) begin : mon
    exp_t e;
    if (rst) begin
      q.delete();
      m_beat     = 0;
      m_row      = 0;
      prev_stall = 1'b0;
    end else begin
      if (prev_stall)
        chk("hold", {13'd0, bus.data_out_valid, bus.data_out[0], bus.data_out_row_last,
                     bus.data_out_tensor_last}, {13'd0, prev_out});
      if (bus.data_out_valid && bus.data_out_ready) begin
        if (q.size() == 0) begin
          chk("spurious_out", 32'd1, 32'd0);
        end else begin
          e = q.pop_front();
          chk("data", {16'd0, bus.data_out[0]}, {16'd0, e.dat});
          chk("row_last", {31'd0, bus.data_out_row_last}, {31'd0, e.rl});
          chk("tensor_last", {31'd0, bus.data_out_tensor_last}, {31'd0, e.tl});
          n_out++;
          if (e.rl) n_rl++;
          if (e.tl) n_tl++;
        end
      end
      prev_stall = bus.data_out_valid && !bus.data_out_ready;
      prev_out   = {bus.data_out_valid, bus.data_out[0], bus.data_out_row_last,
                    bus.data_out_tensor_last};
      if (bus.data_in_valid && bus.bias_valid && bus.data_in_ready) begin
        e.dat = model_add(bus.data_in[0], bus.bias[0]);
        e.rl  = (m_beat == D0 / P - 1);
        e.tl  = e.rl && (m_row == D1 - 1);
        q.push_back(e);
        n_in++;
        if (e.rl) begin
          m_beat = 0;
          m_row  = (m_row == D1 - 1) ? 0 : m_row + 1;
        end else begin
          m_beat++;
        end
      end
    end
  end

  // Called just after a rising edge; returns just after the edge that took the beat.
  task automatic send(input logic [15:0] d, input logic [15:0] b);
    int n;
    n = 0;
    bus.data_in[0]    = d;
    bus.bias[0]       = b;
    bus.data_in_valid = 1'b1;
    bus.bias_valid    = 1'b1;
    @(negedge clk);
    while (!bus.data_in_ready && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (n >= 100) chk("send_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    bus.data_in_valid = 1'b0;
    bus.bias_valid    = 1'b0;
  endtask

  task automatic do_reset();
    rst               = 1'b1;
    bus.data_in_valid = 1'b0;
    bus.bias_valid    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic drain();
    repeat (4) @(posedge clk);
    #1;
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: run did not complete, vectors %0d", vectors);
    $fatal(1, "timeout");
  end

  initial begin : stim
    int  base;
    time t0, t1;
    bus.data_in        = '0;
    bus.bias           = '0;
    bus.data_in_valid  = 1'b1;
    bus.bias_valid     = 1'b1;
    bus.data_out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", {31'd0, bus.data_out_valid}, 32'd0);
    chk("rst_data", {16'd0, bus.data_out[0]}, 32'd0);
    chk("rst_row_last", {31'd0, bus.data_out_row_last}, 32'd0);
    chk("rst_tensor_last", {31'd0, bus.data_out_tensor_last}, 32'd0);
    chk("rst_din_ready", {31'd0, bus.data_in_ready}, 32'd0);
    chk("rst_bias_ready", {31'd0, bus.bias_ready}, 32'd0);
    @(posedge clk);
    #1;
    bus.data_in_valid  = 1'b0;
    bus.bias_valid     = 1'b0;
    rst                = 1'b0;
    bus.data_out_ready = 1'b1;

    send(16'h0040, 16'h0008);
    @(negedge clk);
    chk("basic_latency", {31'd0, bus.data_out_valid}, 32'd1);
    chk("basic_add", {16'd0, bus.data_out[0]}, 32'h0080);
    @(posedge clk); #1;
    send(16'h7FF0, 16'h0008);
    @(negedge clk);
    chk("sat_pos", {16'd0, bus.data_out[0]}, 32'h7FFF);
    @(posedge clk); #1;
    send(16'h8000, 16'hFFF8);
    @(negedge clk);
    chk("sat_neg", {16'd0, bus.data_out[0]}, 32'h8000);
    @(posedge clk); #1;
    send(16'hFFC0, 16'h0004);
    @(negedge clk);
    chk("neg_add", {16'd0, bus.data_out[0]}, 32'hFFE0);
    @(posedge clk); #1;

    // Bias alone must never be consumed.
    drain();
    base              = n_in;
    bus.bias[0]       = 16'h0010;
    bus.bias_valid    = 1'b1;
    bus.data_in_valid = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("stall_bias_ready", {31'd0, bus.bias_ready}, 32'd0);
      chk("stall_din_ready", {31'd0, bus.data_in_ready}, 32'd1);
      chk("stall_no_out", {31'd0, bus.data_out_valid}, 32'd0);
    end
    @(posedge clk); #1;
    chk("stall_no_xfer", n_in - base, 32'd0);
    send(16'h0020, 16'h0010);
    drain();
    chk("stall_one_xfer", n_in - base, 32'd1);

    // Backpressure: two entries fill the buffer, then the readies drop.
    base               = n_out;
    bus.data_out_ready = 1'b0;
    send(16'h0100, 16'h0001);
    send(16'h0101, 16'h0002);
    bus.data_in[0]    = 16'h0102;
    bus.bias[0]       = 16'h0003;
    bus.data_in_valid = 1'b1;
    bus.bias_valid    = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("bp_din_ready", {31'd0, bus.data_in_ready}, 32'd0);
      chk("bp_bias_ready", {31'd0, bus.bias_ready}, 32'd0);
      chk("bp_valid", {31'd0, bus.data_out_valid}, 32'd1);
    end
    @(posedge clk); #1;
    bus.data_out_ready = 1'b1;
    send(16'h0102, 16'h0003);
    for (int i = 3; i < 8; i++) send(16'(16'h0100 + i), 16'(i + 1));
    drain();
    chk("bp_count", n_out - base, 32'd8);

    // Full tensor at one beat per cycle.
    do_reset();
    n_rl = 0;
    n_tl = 0;
    t0   = $time;
    for (int i = 0; i < D0 * D1; i++)
      send(16'($urandom_range(0, 65535)), 16'(int'($urandom_range(0, 8191)) - 4096));
    t1 = $time;
    chk("throughput", 32'((t1 - t0) / 10), 32'd128);
    drain();
    chk("tensor_row_lasts", n_rl, 32'd4);
    chk("tensor_lasts", n_tl, 32'd1);
    send(16'h0001, 16'h0001);
    drain();
    chk("wrap_row_lasts", n_rl, 32'd4);

    // Reset with two entries buffered mid-tensor.
    do_reset();
    for (int i = 0; i < 40; i++) send(16'(i * 3), 16'(i));
    bus.data_out_ready = 1'b0;
    send(16'h0200, 16'h0005);
    @(negedge clk);
    chk("mid_full_ready", {31'd0, bus.data_in_ready}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("mid_rst_valid", {31'd0, bus.data_out_valid}, 32'd0);
    chk("mid_rst_data", {16'd0, bus.data_out[0]}, 32'd0);
    @(posedge clk); #1;
    rst                = 1'b0;
    bus.data_out_ready = 1'b1;
    n_rl               = 0;
    for (int i = 0; i < 31; i++) send(16'(i), 16'h0002);
    drain();
    chk("mid_no_row_last", n_rl, 32'd0);
    send(16'h0300, 16'h0002);
    drain();
    chk("mid_row_last", n_rl, 32'd1);
    chk("queue_empty", q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
